la_scanbist: RTL and testbench
==============================

Name: la_scanbist

Overview:
- Logic-BIST scan sequencer that drives a single scan chain built from the library's scan flops (la_sdffrq).
- It generates se and si and compresses the chain's scan output into a signature.
- Test patterns come from an internal 16-bit LFSR. Responses are folded into a 16-bit MISR.
- Sits between the test/debug register block (start, npat, signature, done) and the chain under test.

Parameters:
- CHAINLEN, 32: number of flops in the attached chain; shift phase length in cycles; min 1.
- PW, 8: width of the npat pattern-count input.
- SEED, 16'hACE1: LFSR seed loaded on start; must be nonzero.

Ports:
- clk  input  1  clock
- nreset  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle run request; ignored while busy=1
- npat  input  PW  number of patterns; sampled on the start cycle
- so  input  1  scan output of the last chain flop
- se  output  1  scan enable to the chain; registered
- si  output  1  scan input to the first chain flop; registered
- busy  output  1  high in SHIFT, CAPTURE and UNLOAD
- done  output  1  one-cycle pulse when the run finishes
- signature  output  16  MISR value; stable from done until the next accepted start

Behaviour:
- Reset values:
  - state IDLE; se=0, si=0, busy=0, done=0.
  - signature/MISR=0, LFSR=SEED, counters=0.
  - Reset is async and legal mid-run: se drops immediately and the run is abandoned.
- LFSR step (Fibonacci, right shift):
  - si source is l[0].
  - fb = l[0]^l[2]^l[3]^l[5]; l_next = {fb, l[15:1]}.
  - Steps once per SHIFT cycle.
- MISR step: m_next = {m[14:0],1'b0} ^ (m[15] ? 16'h002D : 16'h0) ^ {15'b0, so}.
- IDLE:
  - On start with npat==0: go to DONE; MISR cleared.
  - On start with npat!=0: latch npat; LFSR=SEED; MISR=0; pattern count pc=0; shift count=0; go to SHIFT.
- SHIFT (se=1, si=LFSR bit):
  - Lasts exactly CHAINLEN cycles.
  - MISR absorbs so each cycle only when pc>0. The initial load does not compress stale chain contents.
  - After the last shift cycle go to CAPTURE.
- CAPTURE (se=0, si=0):
  - Lasts exactly one cycle; the chain loads functional d.
  - pc increments.
  - If pc==npat go to UNLOAD, else go to SHIFT.
- UNLOAD (se=1, si=0):
  - Lasts CHAINLEN cycles; MISR absorbs so every cycle; LFSR holds.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; go to IDLE.
- Cycle count for npat=N≥1:
  - busy stays high for N*(CHAINLEN+1)+CHAINLEN cycles.
  - done asserts the following cycle.
  - npat==0: done asserts the cycle after start; busy never rises.
- start while busy or in DONE: ignored, with no effect on counters.
- start coincident with the done pulse: ignored; a new start is accepted in IDLE.
- Registered timing: se/si change on the same edge that advances state. The chain samples them on the next edge.
- Counters:
  - Shift counter is width clog2(CHAINLEN+1).
  - pc is PW bits; npat max 2^PW-1 with no wrap.

Decomposition:
- Shared package la_bist_pkg holds:
  - state enum (IDLE, SHIFT, CAPTURE, UNLOAD, DONE);
  - LFSR tap mask 16'h002D and default SEED;
  - MISR polynomial constant 16'h002D.
- One sub-module, la_misr16:
  - 16-bit MISR with en, clr, serial input;
  - reused by future multi-chain variants.
- The LFSR stays inline.

Test Plan:
- CHAINLEN=4, npat=1, SEED=16'hACE1 -> si sequence 1,0,0,0 on the four SHIFT cycles. Then one CAPTURE cycle with se=0, then 4 UNLOAD cycles with si=0. busy high 9 cycles; done pulses once.
- CHAINLEN=4, npat=1, so tied 1 -> signature=16'h000F (MISR 1,3,7,F); initial-load cycles are not compressed.
- CHAINLEN=4, npat=2, so tied 0 -> busy high exactly 14 cycles, se low exactly on cycles 5 and 10, signature=16'h0000.
- npat=0 start -> done one cycle after start, busy never asserts, signature=0.
- Second start pulse mid-SHIFT, plus a start coincident with done -> both ignored; cycle count and signature identical to the single-run result.
- nreset asserted mid-SHIFT (CHAINLEN=32, npat=3) -> se=0, busy=0, signature=0 asynchronously. A subsequent start produces a signature identical to a clean run.

Source files
------------

// File: rtl/la_bist_pkg.sv
// Shared types and constants for the logic-BIST scan sequencer family.
// Holds the sequencer state encoding, LFSR/MISR polynomials and the default seed.
package la_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] MISR_POLY    = 16'h002D;

  // Fibonacci right-shift step: feedback is the XOR of the tapped bits, entering at bit 15.
  function automatic logic [15:0] lfsrStep(input logic [15:0] l);
    return {^(l & LFSR_TAPS), l[15:1]};
  endfunction

endpackage

// File: rtl/la_scanbist_if.sv
// Bundle between the BIST sequencer, its test/debug register block and the scan chain.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface la_scanbist_if #(
  parameter int PW = 8
);

  logic          start;
  logic [PW-1:0] npat;
  logic          so;
  logic          se;
  logic          si;
  logic          busy;
  logic          done;
  logic [15:0]   signature;

  modport master (
    output start,
    output npat,
    output so,
    input  se,
    input  si,
    input  busy,
    input  done,
    input  signature
  );

  modport slave (
    input  start,
    input  npat,
    input  so,
    output se,
    output si,
    output busy,
    output done,
    output signature
  );

endinterface

// File: rtl/la_misr16.sv
// 16-bit single-input signature register; clear has priority over compression.
// Kept standalone so multi-chain variants can instantiate one per chain.
module la_misr16
  import la_bist_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_sin,
  output logic [15:0] o_signature
);

  logic [15:0] r_misr;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_misr <= '0;
    end else if (i_clr) begin
      r_misr <= '0;
    end else if (i_en) begin
      r_misr <= {r_misr[14:0], 1'b0} ^ (r_misr[15] ? MISR_POLY : 16'h0000) ^ {15'b0, i_sin};
    end
  end

  assign o_signature = r_misr;

endmodule

// File: rtl/la_scanbist.sv
// Logic-BIST scan sequencer: loads LFSR patterns into one scan chain, pulses capture,
// and folds the chain's scan output into a MISR signature.
module la_scanbist
  import la_bist_pkg::*;
#(
  parameter int          CHAINLEN = 32,
  parameter int          PW       = 8,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input logic          clk,
  input logic          nreset,
  la_scanbist_if.slave bist
);

  localparam int              SW         = $clog2(CHAINLEN + 1);
  localparam logic [SW-1:0]   LAST_SHIFT = SW'(CHAINLEN - 1);

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [SW-1:0] r_shiftCnt;
  logic [PW-1:0] r_pc;
  logic [PW-1:0] r_npat;
  logic          r_se;
  logic          r_si;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_misrEn;
  logic [15:0]   w_lfsrNext;
  logic [PW-1:0] w_pcNext;
  logic [15:0]   w_signature;

  assign w_lfsrNext = lfsrStep(r_lfsr);
  assign w_pcNext   = r_pc + PW'(1);
  assign w_accept   = (r_state == IDLE) && bist.start;

  // The first load only flushes stale chain contents, so compression waits until pc>0.
  assign w_misrEn = ((r_state == SHIFT) && (r_pc != '0)) || (r_state == UNLOAD);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= IDLE;
      r_lfsr     <= SEED;
      r_shiftCnt <= '0;
      r_pc       <= '0;
      r_npat     <= '0;
      r_se       <= 1'b0;
      r_si       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bist.start) begin
            if (bist.npat == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_npat     <= bist.npat;
              r_lfsr     <= SEED;
              r_pc       <= '0;
              r_shiftCnt <= '0;
              r_state    <= SHIFT;
              r_se       <= 1'b1;
              r_si       <= SEED[0];
              r_busy     <= 1'b1;
            end
          end
        end

        // si is registered, so it is loaded with the bit the LFSR will present next cycle.
        SHIFT: begin
          r_lfsr <= w_lfsrNext;
          if (r_shiftCnt == LAST_SHIFT) begin
            r_shiftCnt <= '0;
            r_state    <= CAPTURE;
            r_se       <= 1'b0;
            r_si       <= 1'b0;
          end else begin
            r_shiftCnt <= r_shiftCnt + SW'(1);
            r_si       <= w_lfsrNext[0];
          end
        end

        CAPTURE: begin
          r_pc <= w_pcNext;
          r_se <= 1'b1;
          if (w_pcNext == r_npat) begin
            r_state <= UNLOAD;
            r_si    <= 1'b0;
          end else begin
            r_state <= SHIFT;
            r_si    <= r_lfsr[0];
          end
        end

        UNLOAD: begin
          if (r_shiftCnt == LAST_SHIFT) begin
            r_shiftCnt <= '0;
            r_state    <= DONE;
            r_se       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_shiftCnt <= r_shiftCnt + SW'(1);
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  la_misr16 u_misr (
    .clk         (clk),
    .nreset      (nreset),
    .i_en        (w_misrEn),
    .i_clr       (w_accept),
    .i_sin       (bist.so),
    .o_signature (w_signature)
  );

  assign bist.se        = r_se;
  assign bist.si        = r_si;
  assign bist.busy      = r_busy;
  assign bist.done      = r_done;
  assign bist.signature = w_signature;

endmodule

// File: tb/tb_la_scanbist.sv
// Testbench for la_scanbist: a 4-flop and a 32-flop instance, each driving a behavioural
// scan chain, checked against a whole-run schedule and signature model.
module tb_la_scanbist;

  localparam logic [15:0] SEED_TB = 16'hACE1;

  typedef logic [3:0] trace_t[$];

  typedef struct {
    bit          big;
    int          np;
    int          soMode;
    int          extraStart;
    bit          startAtDone;
    bit          sigKnown;
    logic [15:0] expSig;
  } vec_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        useBig = 1'b0;
  int          soMode = 2;
  logic [31:0] k4 = 32'h6;
  logic [31:0] k32 = 32'h5A5A_3C3C;
  logic [31:0] chain4 = 32'h9;
  logic [31:0] chain32 = 32'hDEAD_BEEF;

  int nChecks = 0;
  int nFail = 0;

  la_scanbist_if #(.PW(8)) bus4 ();
  la_scanbist_if #(.PW(8)) bus32 ();

  la_scanbist #(.CHAINLEN(4), .PW(8), .SEED(SEED_TB)) dut4 (
    .clk    (clk),
    .nreset (nreset),
    .bist   (bus4)
  );

  la_scanbist #(.CHAINLEN(32), .PW(8), .SEED(SEED_TB)) dut32 (
    .clk    (clk),
    .nreset (nreset),
    .bist   (bus32)
  );

  always #5 clk = ~clk;

  // Functional logic seen by the chain in capture: each flop XORs with its neighbour and a key bit.
  function automatic logic [31:0] captureFn(input logic [31:0] q, input int len, input logic [31:0] k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[i] = q[i] ^ q[(i + 1) % len] ^ k[i];
    return r;
  endfunction

  function automatic logic [31:0] shiftIn(input logic [31:0] q, input int len, input logic b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[i] = (i == 0) ? b : q[i - 1];
    return r;
  endfunction

  // Behavioural scan chains standing in for rows of la_sdffrq flops.
  always @(posedge clk) begin
    chain4  <= bus4.se  ? shiftIn(chain4, 4, bus4.si)    : captureFn(chain4, 4, k4);
    chain32 <= bus32.se ? shiftIn(chain32, 32, bus32.si) : captureFn(chain32, 32, k32);
  end

  assign bus4.so  = (soMode == 0) ? chain4[3]   : (soMode == 1);
  assign bus32.so = (soMode == 0) ? chain32[31] : (soMode == 1);

  logic        obsBusy, obsSe, obsSi, obsDone;
  logic [15:0] obsSig;
  assign obsBusy = useBig ? bus32.busy      : bus4.busy;
  assign obsSe   = useBig ? bus32.se        : bus4.se;
  assign obsSi   = useBig ? bus32.si        : bus4.si;
  assign obsDone = useBig ? bus32.done      : bus4.done;
  assign obsSig  = useBig ? bus32.signature : bus4.signature;

  function automatic logic [15:0] tbLfsr(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [15:0] tbMisr(input logic [15:0] m, input logic b);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h002D : 16'h0000) ^ {15'b0, b};
  endfunction

  // Per-cycle {busy,se,si,done} from the cycle after start through the cycle after done.
  function automatic trace_t expTrace(input int len, input int np);
    trace_t t;
    logic [15:0] l;
    t = {};
    l = SEED_TB;
    if (np > 0) begin
      for (int p = 0; p < np; p++) begin
        for (int j = 0; j < len; j++) begin
          t.push_back({1'b1, 1'b1, l[0], 1'b0});
          l = tbLfsr(l);
        end
        t.push_back(4'b1000);
      end
      for (int j = 0; j < len; j++) t.push_back(4'b1100);
    end
    t.push_back(4'b0001);
    t.push_back(4'b0000);
    return t;
  endfunction

  // Each pattern's captured response is compressed exactly once, last flop first.
  function automatic logic [15:0] modelSig(input int len, input int np, input int mode, input logic [31:0] k);
    logic [15:0] l, m;
    logic [31:0] pat, resp;
    logic        b;
    l = SEED_TB;
    m = '0;
    for (int p = 0; p < np; p++) begin
      pat = '0;
      for (int j = 0; j < len; j++) begin
        pat[len - 1 - j] = l[0];
        l = tbLfsr(l);
      end
      resp = captureFn(pat, len, k);
      for (int j = len - 1; j >= 0; j--) begin
        b = (mode == 0) ? resp[j] : (mode == 1);
        m = tbMisr(m, b);
      end
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic setStart(input logic s, input logic [7:0] n);
    if (useBig) begin
      bus32.start = s;
      bus32.npat  = n;
    end else begin
      bus4.start = s;
      bus4.npat  = n;
    end
  endtask

  task automatic applyStimulus(input vec_t v, output logic [15:0] sigAtDone, output logic [15:0] sigAfter,
                               output int busyCnt, output logic [3:0] firstSi, output bit timedOut,
                               output trace_t actual);
    int cycle, limit, len;
    bit seenDone, nxt;
    len       = v.big ? 32 : 4;
    limit     = v.np * (len + 1) + len + 8;
    useBig    = v.big;
    soMode    = v.soMode;
    actual    = {};
    busyCnt   = 0;
    firstSi   = '0;
    timedOut  = 1'b0;
    seenDone  = 1'b0;
    sigAtDone = '0;
    sigAfter  = '0;
    cycle     = 0;
    @(negedge clk);
    setStart(1'b1, 8'(v.np));
    forever begin
      @(negedge clk);
      cycle++;
      actual.push_back({obsBusy, obsSe, obsSi, obsDone});
      if (obsBusy) busyCnt++;
      if (cycle <= 4) firstSi[4 - cycle] = obsSi;
      nxt = (cycle == v.extraStart) || (obsDone && v.startAtDone);
      setStart(nxt, 8'(v.np + 5));
      if (seenDone) begin
        sigAfter = obsSig;
        break;
      end
      if (obsDone) begin
        seenDone  = 1'b1;
        sigAtDone = obsSig;
      end
      if (cycle >= limit) begin
        timedOut = 1'b1;
        break;
      end
    end
    setStart(1'b0, 8'(v.np));
  endtask

  task automatic runVector(input vec_t v, input string name);
    trace_t act, exp;
    logic [15:0] sigAtDone, sigAfter, want;
    logic [3:0]  firstSi;
    int busyCnt, len, errs, firstBad, n;
    bit timedOut;
    len = v.big ? 32 : 4;
    applyStimulus(v, sigAtDone, sigAfter, busyCnt, firstSi, timedOut, act);
    exp = expTrace(len, v.np);
    errs = (act.size() != exp.size()) ? 1 : 0;
    firstBad = -1;
    n = (act.size() < exp.size()) ? act.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      if (act[i] !== exp[i]) begin
        errs++;
        if (firstBad < 0) firstBad = i;
      end
    end
    checkOutput({name, ".timeout"}, 32'(timedOut), 32'd0);
    checkOutput({name, ".traceErrors"}, 32'(errs), 32'd0);
    if (firstBad >= 0)
      $display("[TB]   %s first differing cycle %0d: got %h, expected %h", name, firstBad + 1, act[firstBad], exp[firstBad]);
    checkOutput({name, ".busyCycles"}, 32'(busyCnt), (v.np == 0) ? 32'd0 : 32'(v.np * (len + 1) + len));
    want = v.sigKnown ? v.expSig : modelSig(len, v.np, v.soMode, v.big ? k32 : k4);
    checkOutput({name, ".signature"}, 32'(sigAtDone), 32'(want));
    checkOutput({name, ".signatureHeld"}, 32'(sigAfter), 32'(want));
    if (!v.big && v.np > 0) checkOutput({name, ".firstSi"}, 32'(firstSi), 32'(4'b1000));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    vec_t rv;

    // soMode: 0 = live chain, 1 = so tied high, 2 = so tied low.
    vecs[0] = '{1'b0, 1,   1, 0, 1'b0, 1'b1, 16'h000F};
    vecs[1] = '{1'b0, 0,   2, 0, 1'b0, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 2,   2, 0, 1'b0, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 1,   1, 2, 1'b1, 1'b1, 16'h000F};
    vecs[4] = '{1'b0, 3,   0, 3, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 255, 0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{1'b1, 3,   0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 1,   1, 0, 1'b0, 1'b0, 16'h0000};

    bus4.start  = 1'b0;
    bus4.npat   = '0;
    bus32.start = 1'b0;
    bus32.npat  = '0;

    #1 nreset = 1'b0;
    #2;
    checkOutput("reset4", 32'({bus4.se, bus4.si, bus4.busy, bus4.done, bus4.signature}), 32'd0);
    checkOutput("reset32", 32'({bus32.se, bus32.si, bus32.busy, bus32.done, bus32.signature}), 32'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of the second pattern's shift.
    useBig = 1'b1;
    soMode = 0;
    @(negedge clk);
    setStart(1'b1, 8'd3);
    @(negedge clk);
    setStart(1'b0, 8'd3);
    repeat (44) @(negedge clk);
    checkOutput("midRun.busySe", 32'({obsBusy, obsSe}), 32'b11);
    #2 nreset = 1'b0;
    #1;
    checkOutput("midReset.controls", 32'({obsSe, obsSi, obsBusy, obsDone}), 32'd0);
    checkOutput("midReset.signature", 32'(obsSig), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    runVector(vecs[6], "afterReset");

    for (int i = 0; i < 6; i++) begin
      k4          = $urandom;
      k32         = $urandom;
      rv.big      = ($urandom_range(0, 1) == 1);
      rv.np       = rv.big ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 6));
      rv.soMode   = int'($urandom_range(0, 2));
      rv.extraStart  = int'($urandom_range(0, 6));
      rv.startAtDone = ($urandom_range(0, 1) == 1);
      rv.sigKnown = 1'b0;
      rv.expSig   = '0;
      runVector(rv, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
